// File: rtl/dcache_fill_pkg.sv
// rtl/dcache_fill_pkg.sv - shared types and constants for the dcache line fill/writeback engine
// Contents: FSM state enum, serial bus command opcodes, bus address width,
//           header geometry and a small max helper for counter sizing.
package dcache_fill_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WB_CMD   = 4'd1,
        WB_ADDR  = 4'd2,
        WB_DATA  = 4'd3,
        WB_GAP   = 4'd4,
        RD_CMD   = 4'd5,
        RD_ADDR  = 4'd6,
        RD_DUMMY = 4'd7,
        RD_DATA  = 4'd8,
        DONE     = 4'd9
    } fill_state_t;

    localparam logic [7:0] CMD_QWRITE = 8'h38;
    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam int         BUS_AW     = 24;

    // Header = {cmd, addr}, sent MSB nibble first.
    localparam int HDR_W     = 8 + BUS_AW;
    localparam int CMD_NIBS  = 2;
    localparam int ADDR_NIBS = BUS_AW / 4;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dcache_fill_qspi_nib_shift.sv
// rtl/dcache_fill_qspi_nib_shift.sv - nibble-serialising shift register for bus command+address headers
// Ports: clk, reset (sync, active-high); load/load_data capture a full {cmd,addr}
//        header; shift moves it up one nibble; nib is the current top nibble.
module qspi_nib_shift
    import dcache_fill_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [HDR_W-1:0] load_data,
    input  logic             shift,
    output logic [3:0]       nib
);

    logic [HDR_W-1:0] sreg;

    // load wins over shift: the read header is loaded on the last gap cycle,
    // when no header is being emitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= load_data;
        end else if (shift) begin
            sreg <= {sreg[HDR_W-5:0], 4'h0};
        end
    end

    assign nib = sreg[HDR_W-1 -: 4];

endmodule

// File: rtl/dcache_fill.sv
// rtl/dcache_fill.sv - dcache miss engine: optional victim writeback, then line fill over a nibble-wide serial bus
// Ports: clk, reset (sync, active-high); start/paddr/fault request a miss;
//        push/pull/tag/dwrite come from dcache; rstrobe_d/wstrobe_d/dread go to dcache;
//        busy/done report progress; mem_cs_n/mem_oe/mem_out/mem_in form the serial bus.
module dcache_fill
    import dcache_fill_pkg::*;
#(
    parameter int LINE_LENGTH = 4,
    parameter int NLINES      = 4,
    parameter int PA          = 22,
    parameter int DUMMY       = 4,
    parameter int CS_GAP      = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [PA-1:0]                      paddr,
    input  logic                               fault,
    input  logic                               push,
    input  logic                               pull,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0]  tag,
    input  logic [3:0]                         dwrite,
    output logic                               rstrobe_d,
    output logic                               wstrobe_d,
    output logic [3:0]                         dread,
    output logic                               busy,
    output logic                               done,
    output logic                               mem_cs_n,
    output logic                               mem_oe,
    output logic [3:0]                         mem_out,
    input  logic [3:0]                         mem_in
);

    localparam int OFF_W   = $clog2(LINE_LENGTH);
    localparam int LINE_W  = PA - OFF_W;
    localparam int NIB     = 2 * LINE_LENGTH;
    localparam int CNT_MAX = max_of4(NIB, DUMMY, CS_GAP, ADDR_NIBS);
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Counter reload values: each state lasts (value + 1) cycles.
    localparam logic [CW-1:0] CNT_CMD   = CW'(CMD_NIBS - 1);
    localparam logic [CW-1:0] CNT_ADDR  = CW'(ADDR_NIBS - 1);
    localparam logic [CW-1:0] CNT_DATA  = CW'(NIB - 1);
    localparam logic [CW-1:0] CNT_GAP   = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] CNT_DUMMY = CW'(DUMMY - 1);

    if (LINE_LENGTH < 2 || (1 << OFF_W) != LINE_LENGTH) begin : g_bad_line_length
        $error("LINE_LENGTH must be a power of two >= 2");
    end
    if (NLINES < 1 || (1 << $clog2(NLINES)) != NLINES) begin : g_bad_nlines
        $error("NLINES must be a power of two");
    end
    if (PA > BUS_AW || PA <= OFF_W) begin : g_bad_pa
        $error("PA must fit the 24-bit bus address");
    end
    if (DUMMY < 1 || CS_GAP < 1) begin : g_bad_timing
        $error("DUMMY and CS_GAP must be >= 1");
    end

    fill_state_t       state, next_state;
    logic [CW-1:0]     cnt, next_cnt;
    logic [LINE_W-1:0] rd_line;
    logic [LINE_W-1:0] rd_line_src;
    logic              accept;
    logic              last;
    logic              hdr_load;
    logic              hdr_shift;
    logic [HDR_W-1:0]  hdr_data;
    logic [3:0]        hdr_nib;
    logic [BUS_AW-1:0] wb_bus_addr;
    logic [BUS_AW-1:0] rd_bus_addr;

    // The byte offset of the miss address is irrelevant: whole lines move.
    logic unused_paddr_offset;
    assign unused_paddr_offset = ^paddr[OFF_W-1:0];

    assign accept = start && pull && !fault;
    assign last   = (cnt == '0);

    // At accept the line address comes straight from paddr; afterwards from
    // the copy latched then, so the read header reload after writeback does
    // not depend on upstream still holding paddr.
    assign rd_line_src = (state == IDLE) ? paddr[PA-1:OFF_W] : rd_line;
    assign wb_bus_addr = BUS_AW'({tag, {OFF_W{1'b0}}});
    assign rd_bus_addr = BUS_AW'({rd_line_src, {OFF_W{1'b0}}});

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_line <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (state == IDLE && accept) begin
                rd_line <= paddr[PA-1:OFF_W];
            end
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt - CW'(1);
        hdr_load   = 1'b0;
        hdr_shift  = 1'b0;
        hdr_data   = {CMD_QREAD, rd_bus_addr};
        rstrobe_d  = 1'b0;
        wstrobe_d  = 1'b0;
        dread      = 4'h0;
        done       = 1'b0;
        mem_cs_n   = 1'b1;
        mem_oe     = 1'b0;
        mem_out    = 4'h0;

        case (state)
            IDLE: begin
                next_cnt = cnt;
                if (accept) begin
                    hdr_load   = 1'b1;
                    hdr_data   = push ? {CMD_QWRITE, wb_bus_addr} : {CMD_QREAD, rd_bus_addr};
                    next_state = push ? WB_CMD : RD_CMD;
                    next_cnt   = CNT_CMD;
                end
            end
            WB_CMD, RD_CMD: begin
                mem_cs_n  = 1'b0;
                mem_oe    = 1'b1;
                mem_out   = hdr_nib;
                hdr_shift = 1'b1;
                if (last) begin
                    next_state = (state == WB_CMD) ? WB_ADDR : RD_ADDR;
                    next_cnt   = CNT_ADDR;
                end
            end
            WB_ADDR: begin
                mem_cs_n  = 1'b0;
                mem_oe    = 1'b1;
                mem_out   = hdr_nib;
                hdr_shift = 1'b1;
                if (last) begin
                    next_state = WB_DATA;
                    next_cnt   = CNT_DATA;
                end
            end
            WB_DATA: begin
                // dcache presents the nibble at its current offset; forwarding it
                // in the same cycle keeps the strobe unbroken across the line.
                mem_cs_n  = 1'b0;
                mem_oe    = 1'b1;
                mem_out   = dwrite;
                rstrobe_d = 1'b1;
                if (last) begin
                    next_state = WB_GAP;
                    next_cnt   = CNT_GAP;
                end
            end
            WB_GAP: begin
                if (last) begin
                    hdr_load   = 1'b1;
                    next_state = RD_CMD;
                    next_cnt   = CNT_CMD;
                end
            end
            RD_ADDR: begin
                mem_cs_n  = 1'b0;
                mem_oe    = 1'b1;
                mem_out   = hdr_nib;
                hdr_shift = 1'b1;
                if (last) begin
                    next_state = RD_DUMMY;
                    next_cnt   = CNT_DUMMY;
                end
            end
            RD_DUMMY: begin
                mem_cs_n = 1'b0;
                if (last) begin
                    next_state = RD_DATA;
                    next_cnt   = CNT_DATA;
                end
            end
            RD_DATA: begin
                mem_cs_n  = 1'b0;
                wstrobe_d = 1'b1;
                dread     = mem_in;
                if (last) begin
                    next_state = DONE;
                    next_cnt   = '0;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
                next_cnt   = '0;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

    qspi_nib_shift u_hdr (
        .clk       (clk),
        .reset     (reset),
        .load      (hdr_load),
        .load_data (hdr_data),
        .shift     (hdr_shift),
        .nib       (hdr_nib)
    );

endmodule

// File: tb/tb_dcache_fill.sv
// tb/tb_dcache_fill.sv - self-checking bench for dcache_fill with a dcache/memory model and per-cycle scoreboard
module tb_dcache_fill;

    localparam int LINE_LENGTH = 4;
    localparam int NLINES      = 4;
    localparam int PA          = 22;
    localparam int DUMMY       = 4;
    localparam int CS_GAP      = 1;
    localparam int NIB         = 2 * LINE_LENGTH;
    localparam int TAG_W       = PA - 2;
    localparam int RD_DATA_AT  = 2 + 6 + DUMMY;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             fault = 1'b0;
    logic             push = 1'b0;
    logic             pull = 1'b0;
    logic [PA-1:0]    paddr = '0;
    logic [TAG_W-1:0] tag = '0;
    logic [3:0]       dwrite;
    logic [3:0]       mem_in;
    logic             rstrobe_d, wstrobe_d, busy, done, mem_cs_n, mem_oe;
    logic [3:0]       dread, mem_out;

    always #5 clk = ~clk;

    dcache_fill #(
        .LINE_LENGTH (LINE_LENGTH),
        .NLINES      (NLINES),
        .PA          (PA),
        .DUMMY       (DUMMY),
        .CS_GAP      (CS_GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .paddr     (paddr),
        .fault     (fault),
        .push      (push),
        .pull      (pull),
        .tag       (tag),
        .dwrite    (dwrite),
        .rstrobe_d (rstrobe_d),
        .wstrobe_d (wstrobe_d),
        .dread     (dread),
        .busy      (busy),
        .done      (done),
        .mem_cs_n  (mem_cs_n),
        .mem_oe    (mem_oe),
        .mem_out   (mem_out),
        .mem_in    (mem_in)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // dcache model: offset advances on either strobe and returns to 0 when it drops.
    logic [3:0] victim   [NIB];
    logic [3:0] fill_mem [NIB];
    logic [3:0] line     [NIB];
    logic       line_valid;
    int         offset  = 0;
    int         bus_cyc = 0;

    always @(posedge clk) begin
        if (start) line_valid <= 1'b0;
        if (rstrobe_d === 1'b1 || wstrobe_d === 1'b1) offset <= offset + 1;
        else offset <= 0;
        if (wstrobe_d === 1'b1) begin
            line[offset % NIB] <= dread;
            if (offset == NIB - 1) line_valid <= 1'b1;
        end
        bus_cyc <= (mem_cs_n === 1'b0) ? bus_cyc + 1 : 0;
    end

    assign dwrite = victim[offset % NIB];

    // Memory model: read data follows cmd(2) + addr(6) + dummy cycles after cs_n falls.
    always_comb begin
        mem_in = 4'h0;
        if (bus_cyc >= RD_DATA_AT && bus_cyc < RD_DATA_AT + NIB) mem_in = fill_mem[bus_cyc - RD_DATA_AT];
    end

    function automatic logic [31:0] mk(input bit b, input bit d, input bit cs, input bit oe,
                                       input logic [3:0] o, input bit rs, input bit ws,
                                       input logic [3:0] dr);
        return {18'b0, b, d, cs, oe, o, rs, ws, dr};
    endfunction

    logic [31:0] obs;
    assign obs = {18'b0, busy, done, mem_cs_n, mem_oe, mem_out, rstrobe_d, wstrobe_d, dread};

    logic [31:0] exp_q[$];
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) check("bus", obs, exp_q.pop_front());
            else check("idle", obs, mk(0, 0, 1, 0, 4'h0, 0, 0, 4'h0));
        end
    end

    task automatic expect_txn(input bit dirty, input logic [23:0] wa, input logic [23:0] ra);
        logic [31:0] hw, hr;
        hw = {8'h38, wa};
        hr = {8'hEB, ra};
        if (dirty) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(mk(1, 0, 0, 1, hw[31-4*i -: 4], 0, 0, 4'h0));
            for (int k = 0; k < NIB; k++) exp_q.push_back(mk(1, 0, 0, 1, victim[k], 1, 0, 4'h0));
            for (int g = 0; g < CS_GAP; g++) exp_q.push_back(mk(1, 0, 1, 0, 4'h0, 0, 0, 4'h0));
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(1, 0, 0, 1, hr[31-4*i -: 4], 0, 0, 4'h0));
        for (int d = 0; d < DUMMY; d++) exp_q.push_back(mk(1, 0, 0, 0, 4'h0, 0, 0, 4'h0));
        for (int k = 0; k < NIB; k++) exp_q.push_back(mk(1, 0, 0, 0, 4'h0, 0, 1, fill_mem[k]));
        exp_q.push_back(mk(1, 1, 1, 0, 4'h0, 0, 0, 4'h0));
    endtask

    task automatic do_miss(input string name, input bit dirty, input logic [PA-1:0] pa,
                           input logic [TAG_W-1:0] tg, input int lat, input bit pester);
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; pull = 1'b1; push = dirty; fault = 1'b0; paddr = pa; tag = tg;
        @(posedge clk); #1;
        start = 1'b0;
        expect_txn(dirty, {2'b00, tg, 2'b00}, {2'b00, pa[PA-1:2], 2'b00});
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            if (pester && cyc == 5) start = 1'b1;
            if (pester && cyc == 6) start = 1'b0;
            if (pester && cyc == 10) fault = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; fault = 1'b0;
        check({name, "_latency"}, cyc, lat);
        @(posedge clk); #1;
        check({name, "_busy_after"}, busy, 1'b0);
        check({name, "_valid"}, line_valid, 1'b1);
        for (int k = 0; k < NIB; k++) check($sformatf("%s_line%0d", name, k), line[k], fill_mem[k]);
        push = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int cyc;
        for (int k = 0; k < NIB; k++) begin
            victim[k]   = 4'(3 * k + 1);
            fill_mem[k] = 4'(k);
        end

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", obs, mk(0, 0, 1, 0, 4'h0, 0, 0, 4'h0));
        reset = 1'b0;
        mon_en = 1'b1;

        do_miss("clean", 1'b0, 22'h012345, 20'h00000, 21, 1'b0);

        for (int k = 0; k < NIB; k++) fill_mem[k] = 4'(8 + k);
        do_miss("dirty", 1'b1, 22'h0F0F0A, 20'h1ABCD, 38, 1'b1);

        @(posedge clk); #1;
        start = 1'b1; pull = 1'b1; fault = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("fault_ignored", {busy, mem_cs_n}, 2'b01);
        fault = 1'b0; pull = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("nopull_ignored", {busy, mem_cs_n}, 2'b01);
        start = 1'b0;

        for (int k = 0; k < NIB; k++) fill_mem[k] = 4'(15 - k);
        @(posedge clk); #1;
        start = 1'b1; pull = 1'b1; push = 1'b0; paddr = 22'h2ABCD5;
        @(posedge clk); #1;
        start = 1'b0;
        mon_en = 1'b0;
        cyc = 0;
        while (wstrobe_d !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_reach_data", wstrobe_d, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_in_data_c3", wstrobe_d, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_idle", {busy, mem_cs_n, wstrobe_d, rstrobe_d, mem_oe}, 5'b01000);
        check("rst_line_invalid", line_valid, 1'b0);
        mon_en = 1'b1;

        do_miss("reissue", 1'b0, 22'h2ABCD5, 20'h00000, 21, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
